// File: rtl/text_writer_if.sv
// Byte-stream input and character-buffer write port of the text writer.
// The slave side is the writer; the master side is the feeder/buffer.
interface text_writer_if #(
  parameter int ADDR_W = 13
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/text_writer.sv
// Converts a byte stream into character-buffer writes for a
// wrap-around text terminal: cursor, CR/LF/BS/FF, line and screen clears.
module text_writer #(
  parameter int         COLS   = 106,
  parameter int         ROWS   = 60,
  parameter int         ADDR_W = 13,
  parameter logic [7:0] FILL   = 8'h20
) (
  input  logic         clk_25,
  input  logic         rst_n,
  text_writer_if.slave bus,
  output logic         busy,
  output logic [6:0]   cursor_col,
  output logic [5:0]   cursor_row
);

  typedef enum logic [1:0] {
    CLR_SCR,
    CLR_LINE,
    IDLE
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(COLS*ROWS-1);
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] CM1_A  = ADDR_W'(COLS-1);
  localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
  localparam logic [6:0]        COL_MX = 7'(COLS-1);
  localparam logic [5:0]        ROW_MX = 6'(ROWS-1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [6:0]        col_q, col_d;
  logic [5:0]        row_q, row_d;
  logic              wen_q, wen_d;
  logic [7:0]        data_q, data_d;

  logic [ADDR_W-1:0] clr_last;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] bs_addr;
  logic [ADDR_W-1:0] nxt_base;
  logic [5:0]        nxt_row;
  logic              is_prt;
  logic              is_lf;
  logic              is_cr;
  logic              is_bs;
  logic              is_ff;

  assign bus.in_ready = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign bus.wr_en    = wen_q;
  assign bus.wr_addr  = addr_q;
  assign bus.wr_data  = data_q;
  assign cursor_col   = col_q;
  assign cursor_row   = row_q;

  // base_q tracks row*COLS so no multiplier is needed
  assign clr_last = (state_q == CLR_SCR) ? LAST_A
                                         : base_q + CM1_A;
  assign cur_addr = base_q + ADDR_W'(col_q);
  assign bs_addr  = base_q + ADDR_W'(col_q - 7'd1);
  assign nxt_row  = (row_q == ROW_MX) ? '0 : row_q + 6'd1;
  assign nxt_base = (row_q == ROW_MX) ? '0 : base_q + COLS_A;

  assign is_prt = (bus.in_data >= 8'h20) && (bus.in_data != 8'h7F);
  assign is_lf  = (bus.in_data == 8'h0A);
  assign is_cr  = (bus.in_data == 8'h0D);
  assign is_bs  = (bus.in_data == 8'h08);
  assign is_ff  = (bus.in_data == 8'h0C);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    col_d   = col_q;
    row_d   = row_q;
    wen_d   = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      CLR_SCR, CLR_LINE: begin
        wen_d  = 1'b1;
        addr_d = cnt_q;
        data_d = FILL;
        cnt_d  = cnt_q + ONE_A;
        if (cnt_q == clr_last) state_d = IDLE;
      end
      IDLE: begin
        if (bus.in_valid) begin
          unique case (1'b1)
            is_prt: begin
              wen_d  = 1'b1;
              addr_d = cur_addr;
              data_d = bus.in_data;
              if (col_q != COL_MX) begin
                col_d = col_q + 7'd1;
              end else begin
                col_d   = '0;
                row_d   = nxt_row;
                base_d  = nxt_base;
                cnt_d   = nxt_base;
                state_d = CLR_LINE;
              end
            end
            is_lf: begin
              col_d   = '0;
              row_d   = nxt_row;
              base_d  = nxt_base;
              cnt_d   = nxt_base;
              state_d = CLR_LINE;
            end
            is_cr: col_d = '0;
            is_bs: begin
              if (col_q != 7'd0) begin
                col_d  = col_q - 7'd1;
                wen_d  = 1'b1;
                addr_d = bs_addr;
                data_d = FILL;
              end
            end
            is_ff: begin
              col_d   = '0;
              row_d   = '0;
              base_d  = '0;
              cnt_d   = '0;
              state_d = CLR_SCR;
            end
            default: ;
          endcase
        end
      end
      default: state_d = CLR_SCR;
    endcase
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_SCR;
      cnt_q   <= '0;
      base_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: doc/text_writer.md
Name: text_writer

Overview:
- Upstream feeder for the VGA text display: converts a byte stream into writes to the shared character buffer (106 cols x 60 rows, 6x8 glyphs, cell address = row*106 + col).
- Handles the cursor, line wrap, CR/LF, backspace and form-feed clear.
- Clears the whole buffer to spaces after reset, and clears each line as the cursor enters it. The display therefore behaves as a wrap-around terminal without scrolling.

Parameters:
- COLS, 106, characters per row (640/6)
- ROWS, 60, rows per screen (480/8)
- ADDR_W, 13, width of the character-buffer address; must satisfy 2^ADDR_W >= COLS*ROWS
- FILL, 8'h20, byte written by every clear and backspace operation

Ports:
- clk_25  input  1  25 MHz pixel/system clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream byte valid
- in_data  input  8  upstream byte (ASCII)
- in_ready  output  1  block accepts a byte this cycle
- wr_en  output  1  character-buffer write strobe
- wr_addr  output  ADDR_W  character-buffer write address
- wr_data  output  8  character-buffer write data
- busy  output  1  high while a screen or line clear is in progress
- cursor_col  output  7  current cursor column, 0..COLS-1
- cursor_row  output  6  current cursor row, 0..ROWS-1

Behaviour:
- All outputs are registered, except in_ready and busy, which decode the registered state.
- States: CLR_SCR, CLR_LINE, IDLE.
  - in_ready = (state==IDLE).
  - busy = !in_ready.
- Reset (rst_n low, asynchronous):
  - state=CLR_SCR, clear counter=0, cursor=(0,0).
  - wr_en=0, wr_addr=0, wr_data=0.
  - in_ready=0, busy=1.
- CLR_SCR:
  - On each clock edge, drive wr_en=1, wr_addr=cnt, wr_data=FILL, then cnt++.
  - The edge that presents addr COLS*ROWS-1 (6359) also moves the state to IDLE.
  - That cycle has in_ready=1.
  - Total: exactly COLS*ROWS write cycles.
- CLR_LINE:
  - Same as CLR_SCR, but covers addresses row*COLS .. row*COLS+COLS-1 for the new cursor_row. That is exactly COLS writes.
  - Then IDLE.
- IDLE:
  - wr_en=0 unless a byte is accepted.
  - A byte is accepted when in_valid && in_ready.
  - Its effect appears on the next cycle's outputs, with one-cycle latency.
- Byte handling, using the cursor (r,c) at the moment of acceptance:
  - Printable, 0x20..0x7E and 0x80..0xFF:
    - Write wr_addr=r*COLS+c, wr_data=in_data.
    - If c<COLS-1, set c=c+1 and stay in IDLE.
    - Otherwise set c=0, r=(r+1) mod ROWS and enter CLR_LINE.
  - 0x0A (LF): no write; c=0, r=(r+1) mod ROWS, enter CLR_LINE.
  - 0x0D (CR): no write; c=0; stay in IDLE.
  - 0x08 (BS):
    - If c>0, set c=c-1 and write FILL at r*COLS+(c-1).
    - If c==0, no write and no cursor change. Backspace never moves to the previous row.
  - 0x0C (FF): no write; cursor=(0,0), cnt=0, enter CLR_SCR.
  - Any other byte (0x00..0x1F not listed above, or 0x7F): accepted and discarded; no write, no cursor change.
- Wrap from the last row: r=ROWS-1 wraps to 0, and row 0 is then cleared by CLR_LINE.
- Boundary conditions:
  - While busy, in_valid is ignored and upstream holds in_data.
  - in_valid dropping mid-stream has no effect.
  - Reset asserted mid-clear or mid-write aborts immediately; the full CLR_SCR restarts after release.
- Address arithmetic:
  - Keep a running base register equal to r*COLS. No multiplier in the datapath.
  - wr_addr never exceeds COLS*ROWS-1.

Test Plan:
- Reset release -> 6360 consecutive cycles with wr_en=1, wr_addr 0..6359 in order, wr_data=0x20. in_ready rises with the last write. Cursor reads (0,0).
- After the initial clear, send 'A','B' back-to-back -> writes (0,0x41) then (1,0x42) on consecutive cycles. Cursor ends at (2,0).
- Send 106 printable bytes from (0,0) -> the last write is at addr 105. Then 106 writes of 0x20 at addrs 106..211 with in_ready=0. Cursor ends at row 1, col 0.
- Place the cursor at (5,59) via LF/CR/bytes, then send LF -> cursor (0,0) and 106 fill writes at addrs 0..105.
- BS at (col 3,row 2) -> write 0x20 at addr 214, cursor col 2. BS at col 0 -> no write, cursor unchanged.
- FF mid-screen -> full 6360-write clear, cursor (0,0). Pulse rst_n low during the clear at addr 3000 -> wr_en drops at once; the clear restarts from addr 0 after release.
